mem_array: RTL and testbench
============================

Name: mem_array

Overview:
Parametrised synchronous RAM for the Game Boy core and the successor to the single-port work RAM. It has one write port, NUM_RD independent read ports with a valid strobe, and a configurable read pipeline depth. An optional post-reset clear sequencer fills the array with a known value. It serves as the common backing store for WRAM, HRAM, VRAM and OAM instances.

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 8, data word width in bits
DEPTH, 65536, number of words, 1 <= DEPTH <= 2**ADDR_W
NUM_RD, 2, number of read ports, 1..4
RD_LAT, 1, read latency in cycles, 1..3
RDW_MODE, 0, same-address read-during-write result: 0 returns old data, 1 returns new data
CLEAR_ON_RST, 1, when 1, the array is filled with CLEAR_VAL after reset
CLEAR_VAL, 8'h00, fill value (width DATA_W)

Ports:
i_clk  in  1  clock, all logic on the rising edge
i_rst_n  in  1  synchronous reset, active-low
i_rd_en  in  NUM_RD  per-port read request
i_rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
i_wr_en  in  1  write strobe
i_wr_addr  in  ADDR_W  write address
i_wr_data  in  DATA_W  write data
o_rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
o_rd_valid  out  NUM_RD  per-port read data valid
o_busy  out  1  clear in progress; all external requests are ignored while high

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - o_rd_data = 0 and o_rd_valid = 0, including all pipeline stages.
  - o_busy = CLEAR_ON_RST.
  - The clear counter is set to 0.
  - Array contents are not touched by reset itself.
- FSM states: ST_CLEAR and ST_RUN.
  - Reset enters ST_CLEAR if CLEAR_ON_RST=1, otherwise ST_RUN.
  - A reset asserted during ST_CLEAR restarts the clear from address 0.
- ST_CLEAR:
  - Writes CLEAR_VAL to address = counter each cycle, then increments the counter.
  - After writing DEPTH-1, moves to ST_RUN. The clear takes exactly DEPTH cycles after reset deassertion.
  - o_busy is high throughout and drops in the first ST_RUN cycle.
  - i_wr_en and i_rd_en are ignored: no array writes from the port, and o_rd_valid stays 0.
- ST_RUN writes: if i_wr_en is high and i_wr_addr < DEPTH, the array is written at the clock edge. Writes with i_wr_addr >= DEPTH are dropped silently.
- ST_RUN reads:
  - A request on port k at edge t produces o_rd_valid[k]=1 and the data at edge t+RD_LAT.
  - Each port is fully pipelined, accepting one request per cycle with no stalls.
  - If i_rd_en[k] is low, o_rd_valid[k]=0 RD_LAT cycles later and o_rd_data[k] holds its last value.
  - An out-of-range read address returns 0, still with valid=1.
- Read-during-write to the same address in the same cycle:
  - RDW_MODE=0: the read returns the pre-write contents.
  - RDW_MODE=1: the read returns i_wr_data (bypass at the array stage).
  - Reads issued on later cycles always see the written data regardless of mode.
- Multiple ports may read the same address in the same cycle, and each receives identical data.
- Read pipeline stages are data/valid shift registers of length RD_LAT-1 after the array output register.
- Invalid parameter values (RD_LAT outside 1..3, NUM_RD outside 1..4, DEPTH > 2**ADDR_W) are rejected by an elaboration-time check.

Decomposition:
- mem_pkg:
  - state enum mem_state_e {ST_CLEAR, ST_RUN}
  - RDW_OLD=0 and RDW_NEW=1 localparams
  - MAX_RD_PORTS=4 and MAX_RD_LAT=3
- Sub-module mem_rd_pipe:
  - Single-port valid/data delay line parametrised by DATA_W and RD_LAT-1.
  - Instantiated NUM_RD times in a generate loop.

Test Plan:
1. Clear: DEPTH=16, CLEAR_ON_RST=1, CLEAR_VAL=8'hFF. Preload garbage via backdoor, then release reset -> o_busy high exactly 16 cycles; reads of addresses 0..15 afterwards return 8'hFF.
2. Latency: RD_LAT=3. Write 8'hA5 to 16'h0010, then read it on port 0 -> o_rd_valid[0] and 8'hA5 appear exactly 3 edges after the request. Back-to-back reads of 0x10, 0x11, 0x12 produce valid on three consecutive cycles.
3. RDW: address 0x20 holds 8'h11. Write 8'h22 to 0x20 and read 0x20 in the same cycle -> returns 8'h11 with RDW_MODE=0 and 8'h22 with RDW_MODE=1. A read on the next cycle returns 8'h22 in both modes.
4. Multi-port: NUM_RD=2. Port 0 reads 0x30 (8'h33) while port 1 reads 0x31 (8'h44), then both read 0x30 -> data is correct per port and both ports show 8'h33 in the same cycle.
5. Busy lockout and mid-clear reset:
   - Assert i_wr_en and i_rd_en during the clear -> no valid pulses, and after the clear the memory is all CLEAR_VAL.
   - Pull i_rst_n low at clear cycle 7 -> o_busy stays high for 16 further cycles after release.
6. Out-of-range: DEPTH=16, ADDR_W=8. Write 8'h77 to 8'h20, then read 8'h20 -> valid=1 with data 0. Address 8'h00 is unaffected.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and limits for the mem_array family of RAM blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_e;

  // Same-address read-during-write result selection
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Legal upper limits for the read side
  localparam int MAX_RD_PORTS = 4;
  localparam int MAX_RD_LAT   = 3;

endpackage

// File: rtl/mem_rd_pipe.sv
// Valid/data delay line that stretches one read port's latency past the array register.
// Latency: STAGES cycles from i_vld/i_dat to o_vld/o_dat.
// Backpressure: none; accepts one beat per cycle, data holds its last valid value.
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_dat,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat
);

  logic [STAGES-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [STAGES];

  // Shift valid every cycle; data advances only alongside a valid so the tail holds
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      dat_q <= '{default: '0};
    end else begin
      vld_q[0] <= i_vld;
      if (i_vld) begin
        dat_q[0] <= i_dat;
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

  assign o_vld = vld_q[STAGES-1];
  assign o_dat = dat_q[STAGES-1];

endmodule

// File: rtl/mem_array.sv
// Synchronous RAM: one write port, NUM_RD pipelined read ports, optional post-reset fill.
// Latency: reads return RD_LAT cycles after the request; writes land at the request edge.
// Backpressure: none; every port takes one request per cycle, all requests dropped while o_busy.
module mem_array
  import mem_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 65536,
  parameter int                NUM_RD       = 2,
  parameter int                RD_LAT       = 1,
  parameter int                RDW_MODE     = 0,
  parameter int                CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD-1:0]        i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_valid,
  output logic                     o_busy
);

  // Word index width; at least one bit so DEPTH=1 still has a legal vector
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Reject unsupported shapes at elaboration
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $error("mem_array: RD_LAT must be 1..%0d", MAX_RD_LAT);
  end
  if (NUM_RD < 1 || NUM_RD > MAX_RD_PORTS) begin : g_bad_num_rd
    $error("mem_array: NUM_RD must be 1..%0d", MAX_RD_PORTS);
  end
  if (DEPTH < 1 || longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $error("mem_array: DEPTH must be 1..2**ADDR_W");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("mem_array: RDW_MODE must be 0 or 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_e        state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt, clr_cnt_nxt;
  logic              run;
  logic              wr_fire;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wdat;

  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_word [NUM_RD];
  logic [NUM_RD-1:0] s0_vld;
  logic [DATA_W-1:0] s0_dat  [NUM_RD];

  assign run     = (state == ST_RUN);
  assign wr_fire = run && i_wr_en && ({1'b0, i_wr_addr} < DEPTH_L);

  // State and clear counter; reset restarts any clear from word 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state and array write-port steering: fill sequencer owns the port while clearing
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    arr_we      = 1'b0;
    arr_idx     = i_wr_addr[IDX_W-1:0];
    arr_wdat    = i_wr_data;
    o_busy      = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        o_busy      = 1'b1;
        arr_we      = 1'b1;
        arr_idx     = clr_cnt;
        arr_wdat    = CLEAR_VAL;
        clr_cnt_nxt = clr_cnt + IDX_W'(1);
        if (clr_cnt == LAST_IDX) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        arr_we = wr_fire;
      end
    endcase
  end

  // Array write; contents are left alone on reset edges
  always_ff @(posedge i_clk) begin
    if (i_rst_n && arr_we) begin
      mem[arr_idx] <= arr_wdat;
    end
  end

  // Per-port array lookup: out-of-range reads yield zero, optional same-cycle write bypass
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_word[k] = '0;
      if ({1'b0, rd_addr[k]} < DEPTH_L) begin
        if (RDW_MODE == RDW_NEW && wr_fire && (i_wr_addr == rd_addr[k])) begin
          rd_word[k] = i_wr_data;
        end else begin
          rd_word[k] = mem[rd_addr[k][IDX_W-1:0]];
        end
      end
    end
  end

  // Array output register; data holds when a port is idle or the fill is running
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s0_vld <= '0;
      s0_dat <= '{default: '0};
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        s0_vld[k] <= run && i_rd_en[k];
        if (run && i_rd_en[k]) begin
          s0_dat[k] <= rd_word[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    assign rd_addr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
    if (RD_LAT > 1) begin : g_pipe
      mem_rd_pipe #(
        .DATA_W(DATA_W),
        .STAGES(RD_LAT - 1)
      ) u_pipe (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_vld  (s0_vld[k]),
        .i_dat  (s0_dat[k]),
        .o_vld  (o_rd_valid[k]),
        .o_dat  (o_rd_data[k*DATA_W +: DATA_W])
      );
    end else begin : g_direct
      assign o_rd_valid[k]                 = s0_vld[k];
      assign o_rd_data[k*DATA_W +: DATA_W] = s0_dat[k];
    end
  end

endmodule

// File: tb/tb_mem_array.sv
// Bench for mem_array: two instances (RD_LAT=3/old-data, RD_LAT=1/new-data) share stimulus.
// Expected reads are queued at issue time with a due cycle; a negedge monitor pops and compares.
// The reference is a plain word array plus a fill countdown, independent of the RTL structure.
module tb_mem_array;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int NRD = 2;

  typedef struct {
    logic [7:0] dat;
    int         due;
  } exp_t;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                  i_rst_n;
  logic [NRD-1:0]        i_rd_en;
  logic [NRD*AW-1:0]     i_rd_addr;
  logic                  i_wr_en;
  logic [AW-1:0]         i_wr_addr;
  logic [DW-1:0]         i_wr_data;
  logic [NRD*DW-1:0]     a_rd_data, b_rd_data;
  logic [NRD-1:0]        a_rd_valid, b_rd_valid;
  logic                  a_busy, b_busy;

  mem_array #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .NUM_RD(NRD), .RD_LAT(3),
    .RDW_MODE(0), .CLEAR_ON_RST(1), .CLEAR_VAL(8'hFF)
  ) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .o_busy(a_busy)
  );

  mem_array #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .NUM_RD(NRD), .RD_LAT(1),
    .RDW_MODE(1), .CLEAR_ON_RST(1), .CLEAR_VAL(8'h5A)
  ) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_busy(b_busy)
  );

  // Reference model configuration per instance
  int         lat_m   [2] = '{3, 1};
  bit         rdw_new [2] = '{1'b0, 1'b1};
  logic [7:0] cv      [2] = '{8'hFF, 8'h5A};

  logic [7:0] mm   [2][256];
  exp_t       q    [2][2][$];
  logic [7:0] hold [2][2];
  int         clear_left = 0;
  int         clr_ptr    = 0;
  int         cyc        = 0;
  int         n_chk      = 0;
  int         n_fail     = 0;
  bit         mon_en     = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock of stimulus: drive, advance the model for the coming edge, then check busy
  task automatic cycle(input logic rst_n, input logic we, input logic [7:0] wa,
                       input logic [7:0] wd, input logic [1:0] re,
                       input logic [7:0] ra0, input logic [7:0] ra1);
    logic [7:0] ra [2];
    logic [7:0] e;
    ra[0] = ra0;
    ra[1] = ra1;
    i_rst_n   = rst_n;
    i_wr_en   = we;
    i_wr_addr = wa;
    i_wr_data = wd;
    i_rd_en   = re;
    i_rd_addr = {ra1, ra0};
    if (!rst_n) begin
      // reads that would surface at or after the reset edge are lost
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          while (q[d][p].size() > 0 && q[d][p][$].due > cyc) void'(q[d][p].pop_back());
      clear_left = DEP;
      clr_ptr    = 0;
    end else if (clear_left > 0) begin
      for (int d = 0; d < 2; d++) mm[d][clr_ptr] = cv[d];
      clr_ptr++;
      clear_left--;
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (re[p]) begin
            if (ra[p] >= DEP)                          e = 8'h00;
            else if (rdw_new[d] && we && wa == ra[p])  e = wd;
            else                                       e = mm[d][ra[p]];
            q[d][p].push_back('{dat: e, due: cyc + lat_m[d]});
          end
        end
      end
      if (we && wa < DEP)
        for (int d = 0; d < 2; d++) mm[d][wa] = wd;
    end
    @(posedge i_clk);
    #1;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) hold[d][p] = 8'h00;
      mon_en = 1'b1;
    end
    chk("busy_a", 32'(a_busy), 32'(clear_left > 0));
    chk("busy_b", 32'(b_busy), 32'(clear_left > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
  endtask

  // Monitor: pop expected reads when due, otherwise require idle valid and held data
  always @(negedge i_clk) begin
    logic       v;
    logic [7:0] x;
    exp_t       ex;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          v = (d == 0) ? a_rd_valid[p] : b_rd_valid[p];
          x = (d == 0) ? a_rd_data[p*8 +: 8] : b_rd_data[p*8 +: 8];
          if (q[d][p].size() > 0 && q[d][p][0].due <= cyc) begin
            ex = q[d][p].pop_front();
            chk($sformatf("rd_valid dut%0d port%0d", d, p), 32'(v), 32'd1);
            chk($sformatf("rd_data dut%0d port%0d", d, p), 32'(x), 32'(ex.dat));
            hold[d][p] = ex.dat;
          end else begin
            chk($sformatf("idle_valid dut%0d port%0d", d, p), 32'(v), 32'd0);
            chk($sformatf("idle_hold dut%0d port%0d", d, p), 32'(x), 32'(hold[d][p]));
          end
        end
      end
    end
  end

  initial begin
    i_rst_n   = 1'b0;
    i_rd_en   = '0;
    i_rd_addr = '0;
    i_wr_en   = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;

    // Reset, then a fill with live requests that must all be ignored
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < DEP; i++)
      cycle(1'b1, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom), 2'b11,
            8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
    for (int i = 0; i < DEP; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b11, 8'(i), 8'(DEP - 1 - i));

    // Latency and back-to-back reads
    cycle(1'b1, 1'b1, 8'h00, 8'hA5, 2'b00, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 8'h01, 8'hB1, 2'b00, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 8'h02, 8'hB2, 2'b00, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 8'h03, 8'hB3, 2'b00, 8'h00, 8'h00);
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b01, 8'(i), 8'h00);
    idle(4);

    // Read-during-write, then the following-cycle read
    cycle(1'b1, 1'b1, 8'h04, 8'h11, 2'b00, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 8'h04, 8'h22, 2'b11, 8'h04, 8'h04);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b11, 8'h04, 8'h04);

    // Multi-port: distinct then shared address
    cycle(1'b1, 1'b1, 8'h06, 8'h33, 2'b00, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 8'h07, 8'h44, 2'b00, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b11, 8'h06, 8'h07);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b11, 8'h06, 8'h06);

    // Out-of-range write dropped, out-of-range read returns zero with valid
    cycle(1'b1, 1'b1, 8'h20, 8'h77, 2'b00, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b11, 8'h20, 8'h00);
    idle(4);

    // Random traffic, mostly in range so same-address collisions are frequent
    for (int i = 0; i < 400; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 8'($urandom),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 19)), 8'($urandom_range(0, 19)));
    idle(4);

    // Memory now holds arbitrary data; reset, interrupt the fill at cycle 7, let it finish
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom), 2'b11, 8'h01, 8'h02);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < DEP; i++)
      cycle(1'b1, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom), 2'b11, 8'h03, 8'h04);
    for (int i = 0; i < DEP; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b11, 8'(i), 8'(i));
    idle(6);

    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("drained dut%0d port%0d", d, p), 32'(q[d][p].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
